// File: rtl/stopwatch_pkg.sv
// Shared encodings and default sizing for the stopwatch control path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CNT_CLEAR = 2'b00,
    CNT_COUNT = 2'b01,
    CNT_HOLD  = 2'b10
  } cnt_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int DEF_LAP_DEPTH = 4;
  localparam int DEF_TW        = 24;

endpackage

// File: rtl/lap_buffer.sv
// Circular lap snapshot store with saturating fill count and a read port
// addressed relative to the newest entry (1 = newest).
module lap_buffer #(
  parameter int LAP_DEPTH = 4,
  parameter int TW        = 24,
  localparam int PW       = $clog2(LAP_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_data,
  input  logic [CW-1:0] rd_idx,
  output logic [TW-1:0] rd_data,
  output logic [CW-1:0] lap_cnt
);

  logic [TW-1:0] mem [LAP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_slot;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      lap_cnt <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (lap_cnt != CW'(LAP_DEPTH))
        lap_cnt <= lap_cnt + CW'(1);
    end
  end

  // Slot contents are data only; a stale slot is never visible because
  // the count gates which relative indices can be selected.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_slot = PW'(CW'(wr_ptr) - rd_idx);
  assign rd_data = mem[rd_slot];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button event detection, IDLE/RUN/PAUSE sequencing, lap capture and
// registered live/lap display selection for the stopwatch.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = DEF_LAP_DEPTH,
  parameter int TW        = DEF_TW,
  localparam int CW       = $clog2(LAP_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start_pause,
  input  logic          i_stop,
  input  logic          i_lap,
  input  logic          i_view,
  input  logic [TW-1:0] i_time,
  output logic [1:0]    cnt_ctrl,
  output logic [1:0]    o_state,
  output logic [TW-1:0] o_disp_time,
  output logic [CW-1:0] o_lap_cnt,
  output logic [CW-1:0] o_view_idx
);

  state_e        state, state_n;
  logic [3:0]    btn, btn_q, ev;
  logic          ev_stop, ev_sp, ev_lap, ev_view;
  logic          lap_wr, lap_clr;
  logic [CW-1:0] view_idx;
  logic [TW-1:0] lap_rd;
  logic [TW-1:0] disp_p1;

  assign btn = {i_stop, i_start_pause, i_lap, i_view};
  assign ev  = btn & ~btn_q;

  // Previous levels reset high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= '1;
    else     btn_q <= btn;
  end

  assign ev_stop = ev[3];
  assign ev_sp   = ev[2] & ~ev[3];
  assign ev_lap  = ev[1] & ~(|ev[3:2]);
  assign ev_view = ev[0] & ~(|ev[3:1]);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (ev_sp) state_n = ST_RUN;
      ST_RUN: begin
        if (ev_stop)    state_n = ST_IDLE;
        else if (ev_sp) state_n = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ev_stop)    state_n = ST_IDLE;
        else if (ev_sp) state_n = ST_RUN;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_ctrl = CNT_CLEAR;
    case (state)
      ST_RUN:   cnt_ctrl = CNT_COUNT;
      ST_PAUSE: cnt_ctrl = CNT_HOLD;
      default:  cnt_ctrl = CNT_CLEAR;
    endcase
  end

  assign o_state = state;
  assign lap_wr  = (state == ST_RUN) && ev_lap;
  assign lap_clr = (state != ST_IDLE) && (state_n == ST_IDLE);

  lap_buffer #(
    .LAP_DEPTH (LAP_DEPTH),
    .TW        (TW)
  ) u_lap_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr     (lap_clr),
    .wr_en   (lap_wr),
    .wr_data (i_time),
    .rd_idx  (view_idx),
    .rd_data (lap_rd),
    .lap_cnt (o_lap_cnt)
  );

  // View index cycles live -> newest .. oldest -> live, only while paused.
  always_ff @(posedge clk) begin
    if (rst || lap_clr) begin
      view_idx <= '0;
    end else if (state == ST_PAUSE) begin
      if (state_n != ST_PAUSE)
        view_idx <= '0;
      else if (ev_view)
        view_idx <= (view_idx >= o_lap_cnt) ? '0 : view_idx + CW'(1);
    end
  end

  assign o_view_idx = view_idx;

  // Stage p1: registered display selection.
  always_ff @(posedge clk) begin
    if (rst) disp_p1 <= '0;
    else     disp_p1 <= (view_idx == '0) ? i_time : lap_rd;
  end

  assign o_disp_time = disp_p1;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed, table-driven bench for stopwatch_ctrl with hand-written
// sequences for reset, hold and long-interval cases.
module tb_stopwatch_ctrl;

  localparam int LAP_DEPTH = 4;
  localparam int TW        = 24;
  localparam int CW        = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start_pause, i_stop, i_lap, i_view;
  logic [TW-1:0] i_time;
  logic [1:0]    cnt_ctrl, o_state;
  logic [TW-1:0] o_disp_time;
  logic [CW-1:0] o_lap_cnt, o_view_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          sp, st, lp, vw;
    logic [TW-1:0] tm;
    logic [1:0]    es, ecc;
    logic [CW-1:0] elc, evi;
    logic          dchk;
    logic [TW-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  stopwatch_ctrl #(.LAP_DEPTH(LAP_DEPTH), .TW(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start_pause (i_start_pause),
    .i_stop        (i_stop),
    .i_lap         (i_lap),
    .i_view        (i_view),
    .i_time        (i_time),
    .cnt_ctrl      (cnt_ctrl),
    .o_state       (o_state),
    .o_disp_time   (o_disp_time),
    .o_lap_cnt     (o_lap_cnt),
    .o_view_idx    (o_view_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic btns(input logic sp, input logic st, input logic lp, input logic vw);
    i_start_pause = sp; i_stop = st; i_lap = lp; i_view = vw;
  endtask

  task automatic chk_ctl(input string name, input logic [1:0] es, input logic [1:0] ecc,
                         input logic [CW-1:0] elc, input logic [CW-1:0] evi);
    chk({name, ".state"}, 32'(o_state), 32'(es));
    chk({name, ".cnt_ctrl"}, 32'(cnt_ctrl), 32'(ecc));
    chk({name, ".lap_cnt"}, 32'(o_lap_cnt), 32'(elc));
    chk({name, ".view_idx"}, 32'(o_view_idx), 32'(evi));
  endtask

  task automatic add(input logic sp, input logic st, input logic lp, input logic vw,
                     input logic [TW-1:0] tm, input logic [1:0] es, input logic [1:0] ecc,
                     input logic [CW-1:0] elc, input logic [CW-1:0] evi,
                     input logic dchk, input logic [TW-1:0] ed);
    vec_t v;
    v.sp = sp; v.st = st; v.lp = lp; v.vw = vw; v.tm = tm;
    v.es = es; v.ecc = ecc; v.elc = elc; v.evi = evi; v.dchk = dchk; v.ed = ed;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    btns(1, 0, 0, 0);
    i_time = 24'h0;

    // Reset with start_pause held high.
    step(); step();
    chk_ctl("reset", 2'd0, 2'b00, 0, 0);
    chk("reset.disp", 32'(o_disp_time), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_through_reset.state", 32'(o_state), 32'd0);
      chk("held_through_reset.cnt_ctrl", 32'(cnt_ctrl), 32'd0);
    end

    // sp st lp vw time  state cc lapcnt view dchk disp
    add(0,0,0,0, 24'h0,     0, 0, 0, 0, 0, 24'h0);
    add(1,0,0,0, 24'h0,     1, 1, 0, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 0, 0, 0, 24'h0);
    add(0,0,1,0, 24'h101,   1, 1, 1, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 1, 0, 0, 24'h0);
    add(0,0,1,0, 24'h102,   1, 1, 2, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 2, 0, 0, 24'h0);
    add(0,0,1,0, 24'h103,   1, 1, 3, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 3, 0, 0, 24'h0);
    add(0,0,1,0, 24'h104,   1, 1, 4, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 4, 0, 0, 24'h0);
    add(0,0,1,0, 24'h105,   1, 1, 4, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 4, 0, 0, 24'h0);
    add(0,0,0,1, 24'h0,     1, 1, 4, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     1, 1, 4, 0, 0, 24'h0);
    add(1,0,0,0, 24'h0,     2, 2, 4, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     2, 2, 4, 0, 0, 24'h0);
    add(0,0,0,1, 24'h999,   2, 2, 4, 1, 1, 24'h999);
    add(0,0,0,0, 24'h999,   2, 2, 4, 1, 1, 24'h105);
    add(0,0,0,1, 24'h999,   2, 2, 4, 2, 1, 24'h105);
    add(0,0,0,0, 24'h999,   2, 2, 4, 2, 1, 24'h104);
    add(0,0,0,1, 24'h999,   2, 2, 4, 3, 1, 24'h104);
    add(0,0,0,0, 24'h999,   2, 2, 4, 3, 1, 24'h103);
    add(0,0,0,1, 24'h999,   2, 2, 4, 4, 1, 24'h103);
    add(0,0,0,0, 24'h999,   2, 2, 4, 4, 1, 24'h102);
    add(0,0,0,1, 24'h999,   2, 2, 4, 0, 1, 24'h102);
    add(0,0,0,0, 24'h777,   2, 2, 4, 0, 1, 24'h777);
    add(0,0,0,1, 24'h777,   2, 2, 4, 1, 0, 24'h0);
    add(0,0,0,0, 24'h777,   2, 2, 4, 1, 0, 24'h0);
    add(1,0,0,0, 24'h777,   1, 1, 4, 0, 0, 24'h0);
    add(0,0,0,0, 24'h777,   1, 1, 4, 0, 0, 24'h0);
    add(1,1,1,0, 24'h555,   0, 0, 0, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     0, 0, 0, 0, 0, 24'h0);
    add(0,0,1,0, 24'h0,     0, 0, 0, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     0, 0, 0, 0, 0, 24'h0);
    add(0,0,0,1, 24'h0,     0, 0, 0, 0, 0, 24'h0);
    add(0,0,0,0, 24'h0,     0, 0, 0, 0, 0, 24'h0);

    foreach (vecs[k]) begin
      btns(vecs[k].sp, vecs[k].st, vecs[k].lp, vecs[k].vw);
      i_time = vecs[k].tm;
      step();
      chk_ctl($sformatf("vec%0d", k), vecs[k].es, vecs[k].ecc, vecs[k].elc, vecs[k].evi);
      if (vecs[k].dchk)
        chk($sformatf("vec%0d.disp", k), 32'(o_disp_time), 32'(vecs[k].ed));
    end

    // Start, then a second press 20 cycles later, then a third.
    btns(1, 0, 0, 0); step();
    chk("sp1.cnt_ctrl", 32'(cnt_ctrl), 32'b01);
    btns(0, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      step();
      chk("run_hold.cnt_ctrl", 32'(cnt_ctrl), 32'b01);
    end
    btns(1, 0, 0, 0); step();
    chk("sp2.cnt_ctrl", 32'(cnt_ctrl), 32'b10);
    btns(0, 0, 0, 0); step();
    btns(1, 0, 0, 0); step();
    chk("sp3.cnt_ctrl", 32'(cnt_ctrl), 32'b01);
    btns(0, 0, 0, 0); step();

    // Held lap button is one event.
    i_time = 24'h000201;
    btns(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_lap.lap_cnt", 32'(o_lap_cnt), 32'd1);
    end
    btns(0, 0, 0, 0); step();
    i_time = 24'h000202;
    btns(0, 0, 1, 0); step();
    chk("lap2.lap_cnt", 32'(o_lap_cnt), 32'd2);
    btns(0, 0, 0, 0); step();

    // Pause, lap ignored, view to index 2, then reset mid-operation.
    btns(1, 0, 0, 0); step();
    btns(0, 0, 0, 0); step();
    btns(0, 0, 1, 0); step();
    chk("pause_lap.lap_cnt", 32'(o_lap_cnt), 32'd2);
    btns(0, 0, 0, 0); step();
    btns(0, 0, 0, 1); step();
    btns(0, 0, 0, 0); step();
    btns(0, 0, 0, 1); step();
    chk_ctl("pre_reset", 2'd2, 2'b10, 2, 2);
    btns(0, 0, 0, 0); step();
    chk("pre_reset.disp", 32'(o_disp_time), 32'h000201);
    rst = 1'b1;
    btns(1, 0, 0, 1);
    step();
    chk_ctl("mid_reset", 2'd0, 2'b00, 0, 0);
    chk("mid_reset.disp", 32'(o_disp_time), 32'h0);
    rst = 1'b0;
    btns(0, 0, 0, 0);
    step();
    chk("post_reset.state", 32'(o_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
